// File: rtl/obstacle_mem_arbiter.sv
// obstacle_mem_arbiter
//   Shares the single-port obstacle sprite memory between the video
//   obstacle fetcher (read-only, priority) and the host (read/write).
//   A video streak counter bounds how long a pending host request waits.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   vid_req/vid_addr                video read request and word address
//   vid_gnt                         video request accepted (combinational)
//   vid_rvalid/vid_rdata            video read response, 1 cycle after grant
//   host_req/host_write/host_addr   host request, direction and word address
//   host_byteenable/host_wdata      host write lanes and data
//   host_gnt                        host request accepted (combinational)
//   host_rvalid/host_rdata          host read response, 1 cycle after grant
//   mem_*                           memory pins; mem_readdata is the memory's
//                                   registered output (1-cycle latency)
module obstacle_mem_arbiter #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int MAX_VID_STREAK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic                  vid_gnt,
    output logic                  vid_rvalid,
    output logic [DATA_W-1:0]     vid_rdata,
    input  logic                  host_req,
    input  logic                  host_write,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W/8-1:0]   host_byteenable,
    input  logic [DATA_W-1:0]     host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_W-1:0]     host_rdata,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_debugaccess,
    output logic                  mem_clken,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_VID_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                host_wins;
    logic                rd_vid;
    logic                rd_host;
    logic [DATA_W-1:0]   vid_rdata_q;
    logic [DATA_W-1:0]   host_rdata_q;

    // Host takes the slot when video is absent or has used up its streak.
    always_comb begin
        host_wins = host_req && (!vid_req || (streak == STREAK_MAX));
        host_gnt  = !reset && host_wins;
        vid_gnt   = !reset && vid_req && !host_wins;
    end

    always_comb begin
        mem_address    = vid_addr;
        mem_byteenable = {BE_W{1'b1}};
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (host_gnt) begin
            mem_address    = host_addr;
            mem_chipselect = 1'b1;
            if (host_write) begin
                mem_write      = 1'b1;
                mem_byteenable = host_byteenable;
            end
        end else if (vid_gnt) begin
            mem_chipselect = 1'b1;
        end
    end

    assign mem_debugaccess = mem_write;
    assign mem_clken       = 1'b1;
    assign mem_writedata   = host_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak       <= '0;
            rd_vid       <= 1'b0;
            rd_host      <= 1'b0;
            vid_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (host_gnt || !host_req) begin
                streak <= '0;
            end else if (vid_gnt && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
            end
            rd_vid  <= vid_gnt;
            rd_host <= host_gnt && !host_write;
            if (rd_vid) begin
                vid_rdata_q <= mem_readdata;
            end
            if (rd_host) begin
                host_rdata_q <= mem_readdata;
            end
        end
    end

    // Masking with reset drops a response whose grant preceded reset.
    assign vid_rvalid  = rd_vid && !reset;
    assign host_rvalid = rd_host && !reset;
    assign vid_rdata   = vid_rvalid  ? mem_readdata : vid_rdata_q;
    assign host_rdata  = host_rvalid ? mem_readdata : host_rdata_q;

endmodule

// File: tb/tb_obstacle_mem_arbiter.sv
module tb_obstacle_mem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int MAXS   = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              host_req;
    logic              host_write;
    logic [ADDR_W-1:0] host_addr;
    logic [3:0]        host_byteenable;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_debugaccess;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    obstacle_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_VID_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
        .host_byteenable(host_byteenable), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_debugaccess(mem_debugaccess), .mem_clken(mem_clken),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with registered read data.
    logic [DATA_W-1:0] mem_arr [0:2047];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            mem_readdata <= mem_arr[mem_address];
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:2047];
    int          checks = 0;
    int          errors = 0;
    int          m_wait = 0;      // video grants given while host has been waiting
    logic        pend_v = 1'b0, pend_h = 1'b0;
    logic [31:0] pend_vd = '0, pend_hd = '0;
    logic [31:0] hold_v = '0, hold_h = '0;
    logic        s_vg, s_hg;
    int          host_wait_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs must already be applied. Returns 1 time unit
    // after the next rising edge.
    task automatic cycle();
        logic hw, ev, eh;
        logic [3:0] ebe;
        #1;
        chk1("vid_rvalid", vid_rvalid, pend_v && !reset);
        chk1("host_rvalid", host_rvalid, pend_h && !reset);
        chk1("rvalid_exclusive", vid_rvalid && host_rvalid, 1'b0);
        if (!reset) begin
            if (pend_v) hold_v = pend_vd;
            if (pend_h) hold_h = pend_hd;
            chk("vid_rdata", vid_rdata, hold_v);
            chk("host_rdata", host_rdata, hold_h);
        end

        hw  = host_req && (!vid_req || m_wait >= MAXS);
        eh  = !reset && hw;
        ev  = !reset && vid_req && !hw;
        ebe = (eh && host_write) ? host_byteenable : 4'hF;
        s_vg = vid_gnt;
        s_hg = host_gnt;
        chk1("vid_gnt", vid_gnt, ev);
        chk1("host_gnt", host_gnt, eh);
        chk1("mem_chipselect", mem_chipselect, ev || eh);
        chk1("mem_write", mem_write, eh && host_write);
        chk1("mem_debugaccess", mem_debugaccess, eh && host_write);
        chk1("mem_clken", mem_clken, 1'b1);
        chk("mem_byteenable", 32'(mem_byteenable), 32'(ebe));
        if (eh || ev)
            chk("mem_address", 32'(mem_address), 32'(eh ? host_addr : vid_addr));
        if (eh && host_write)
            chk("mem_writedata", mem_writedata, host_wdata);

        pend_v  = ev;
        pend_vd = ref_mem[vid_addr];
        pend_h  = eh && !host_write;
        pend_hd = ref_mem[host_addr];
        if (eh && host_write)
            for (int b = 0; b < 4; b++)
                if (host_byteenable[b]) ref_mem[host_addr][8*b +: 8] = host_wdata[8*b +: 8];

        if (reset || !host_req || eh) m_wait = 0;
        else if (ev) m_wait = m_wait + 1;

        if (reset) begin
            hold_v = '0;
            hold_h = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req = 1'b0; host_req = 1'b0; host_write = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 2048; i++) begin
            v = $urandom;
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[5] = 32'h12345678; ref_mem[5] = 32'h12345678;
        mem_arr[1] = 32'hAAAA0001; ref_mem[1] = 32'hAAAA0001;
        mem_arr[2] = 32'hBBBB0002; ref_mem[2] = 32'hBBBB0002;

        // Reset held with both requests pending
        reset = 1'b1; vid_req = 1'b1; vid_addr = 11'h005;
        host_req = 1'b1; host_write = 1'b1; host_addr = 11'h7FF;
        host_byteenable = 4'hF; host_wdata = 32'hDEADBEEF;
        repeat (3) cycle();

        // First cycle out of reset: video wins, reads 0x005
        reset = 1'b0;
        cycle();
        chk1("post_reset_vid_gnt", s_vg, 1'b1);
        chk1("vid_read_rvalid", vid_rvalid, 1'b1);
        chk("vid_read_data", vid_rdata, 32'h12345678);
        chk1("vid_read_host_rvalid", host_rvalid, 1'b0);

        // Host write, partial write, read back
        vid_req = 1'b0;
        cycle();
        host_wdata = 32'h0000CAFE; host_byteenable = 4'h3;
        cycle();
        host_write = 1'b0;
        cycle();
        idle_inputs();
        chk1("wr_rd_rvalid", host_rvalid, 1'b1);
        chk("wr_rd_merge", host_rdata, 32'hDEADCAFE);
        cycle();

        // Starvation bound: 8 video then 1 host, three times
        vid_req = 1'b1; vid_addr = 11'h010;
        host_req = 1'b1; host_write = 1'b0; host_addr = 11'h020;
        for (int i = 0; i < 27; i++) begin
            cycle();
            chk1("starve_host_gnt", s_hg, (i % 9) == 8);
        end
        idle_inputs();
        cycle();

        // Alternating routing
        for (int i = 0; i < 8; i++) begin
            vid_req  = (i % 2) == 0; vid_addr  = 11'h001;
            host_req = (i % 2) == 1; host_addr = 11'h002; host_write = 1'b0;
            cycle();
            if ((i % 2) == 0) chk("route_vid", vid_rdata, 32'hAAAA0001);
            else              chk("route_host", host_rdata, 32'hBBBB0002);
        end
        idle_inputs();
        cycle();

        // Reset right after a video read grant
        vid_req = 1'b1; vid_addr = 11'h003;
        cycle();
        reset = 1'b1; vid_req = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Randomized traffic obeying hold-until-granted
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            if (!vid_req || s_vg) begin
                vid_req  = $urandom_range(0, 3) != 0;
                vid_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!host_req || s_hg) begin
                host_req        = $urandom_range(0, 1) == 1;
                host_write      = $urandom_range(0, 1) == 1;
                host_addr       = ADDR_W'($urandom_range(0, 15));
                host_byteenable = 4'($urandom_range(0, 15));
                host_wdata      = $urandom;
            end
            reset = $urandom_range(0, 79) == 0;
            cycle();
            if (reset || !host_req) host_wait_cycles = 0;
            else if (s_hg) begin
                chk1("host_wait_bound", host_wait_cycles <= MAXS, 1'b1);
                host_wait_cycles = 0;
            end else host_wait_cycles++;
            if (reset) begin
                s_vg = 1'b0;
                s_hg = 1'b0;
            end
        end
        reset = 1'b0;
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
